// File: rtl/ps2_kbd_fifo_if.sv
// ---------------------------------------------------------------------------
// ps2_kbd_fifo_if
// CPU-side bus of the PS/2 keyboard receiver.
//   raw_mode   CPU -> kbd  1 = push raw scancodes, 0 = push translated chars
//   kbd_rd     CPU -> kbd  pop the FIFO head (one pop per cycle high)
//   err_clr    CPU -> kbd  clear the sticky error flags
//   kbd        kbd -> CPU  FIFO head, 0 when empty
//   kbd_strb   kbd -> CPU  FIFO not empty
//   kbd_count  kbd -> CPU  number of entries held
//   frame_err  kbd -> CPU  sticky parity / stop-bit / timeout error
//   overflow   kbd -> CPU  sticky push-while-full
// master = CPU bus logic, slave = keyboard receiver.
// ---------------------------------------------------------------------------
interface ps2_kbd_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic          raw_mode;
   logic          kbd_rd;
   logic          err_clr;
   logic [7:0]    kbd;
   logic          kbd_strb;
   logic [CW-1:0] kbd_count;
   logic          frame_err;
   logic          overflow;

   modport master (
      output raw_mode, kbd_rd, err_clr,
      input  kbd, kbd_strb, kbd_count, frame_err, overflow
   );

   modport slave (
      input  raw_mode, kbd_rd, err_clr,
      output kbd, kbd_strb, kbd_count, frame_err, overflow
   );
endinterface

// File: rtl/ps2_kbd_fifo.sv
// ---------------------------------------------------------------------------
// ps2_kbd_fifo
// PS/2 keyboard receiver for the 8-bit computer, fully in the system clock
// domain. Synchronises and filters the PS/2 lines, frames bytes (odd parity,
// stop bit, mid-frame timeout), tracks break/extended/shift state and pushes
// Apple-style characters (bit 7 set) or raw scancodes into an output FIFO.
// Ports:
//   clock       system clock
//   kbd_clr     asynchronous active-high reset
//   ps2_clk_in  raw PS/2 clock (asynchronous)
//   ps2_dat_in  raw PS/2 data  (asynchronous)
//   bus         CPU-side interface (slave modport), see ps2_kbd_fifo_if
// ---------------------------------------------------------------------------
module ps2_kbd_fifo #(
   parameter int FILTER_LEN  = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 10000
) (
   input  logic           clock,
   input  logic           kbd_clr,
   input  logic           ps2_clk_in,
   input  logic           ps2_dat_in,
   ps2_kbd_fifo_if.slave  bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   // ---------------- input conditioning ----------------
   // index 0 = PS/2 clock, index 1 = PS/2 data
   logic [1:0] w_raw;
   logic [1:0] w_filt;
   assign w_raw = {ps2_dat_in, ps2_clk_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         logic [1:0]            r_sync;
         logic [FILTER_LEN-1:0] r_hist;
         logic                  r_filt;

         always_ff @(posedge clock or posedge kbd_clr) begin
            if (kbd_clr) begin
               r_sync <= '1;
               r_hist <= '1;
               r_filt <= 1'b1;
            end else begin
               r_sync <= {r_sync[0], w_raw[gi]};
               r_hist <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
               // Change only on a unanimous history; mixed history holds.
               if (&r_hist)
                  r_filt <= 1'b1;
               else if (~|r_hist)
                  r_filt <= 1'b0;
            end
         end
         assign w_filt[gi] = r_filt;
      end
   endgenerate

   logic r_clk_prev;
   logic w_fall;
   logic w_dat;
   assign w_fall = r_clk_prev & ~w_filt[0];
   assign w_dat  = w_filt[1];

   // ---------------- frame FSM ----------------
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t        r_state, w_state_next;
   logic [2:0]    r_bitcnt, w_bitcnt_next;
   logic [7:0]    r_shift, w_shift_next;
   logic          r_parity, w_parity_next;
   logic [TW-1:0] r_to_cnt, w_to_cnt_next;
   logic          w_emit;
   logic          w_frame_bad;

   always_ff @(posedge clock or posedge kbd_clr) begin
      if (kbd_clr) begin
         r_clk_prev <= 1'b1;
         r_state    <= S_IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_to_cnt   <= '0;
      end else begin
         r_clk_prev <= w_filt[0];
         r_state    <= w_state_next;
         r_bitcnt   <= w_bitcnt_next;
         r_shift    <= w_shift_next;
         r_parity   <= w_parity_next;
         r_to_cnt   <= w_to_cnt_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_bitcnt_next = r_bitcnt;
      w_shift_next  = r_shift;
      w_parity_next = r_parity;
      w_to_cnt_next = '0;
      w_emit        = 1'b0;
      w_frame_bad   = 1'b0;

      if (w_fall) begin
         case (r_state)
            S_IDLE: begin
               if (!w_dat) begin
                  w_state_next  = S_DATA;
                  w_bitcnt_next = '0;
               end
            end
            S_DATA: begin
               w_shift_next  = {w_dat, r_shift[7:1]};   // LSB arrives first
               w_bitcnt_next = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7)
                  w_state_next = S_PARITY;
            end
            S_PARITY: begin
               w_parity_next = w_dat;
               w_state_next  = S_STOP;
            end
            S_STOP: begin
               if (w_dat && (^{r_shift, r_parity}))
                  w_emit = 1'b1;
               else
                  w_frame_bad = 1'b1;
               w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
         endcase
      end else if (r_state != S_IDLE) begin
         // Gap since the last falling edge is too long: drop the partial byte.
         if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            w_state_next = S_IDLE;
            w_frame_bad  = 1'b1;
         end else begin
            w_to_cnt_next = r_to_cnt + TW'(1);
         end
      end
   end

   // ---------------- decoder ----------------
   logic       r_emit;
   logic [7:0] r_byte;
   logic       r_break, w_break_next;
   logic       r_ext, w_ext_next;
   logic       r_lshift, w_lshift_next;
   logic       r_rshift, w_rshift_next;
   logic       w_push;
   logic [7:0] w_push_data;
   logic [8:0] w_xl;

   // {valid, character}; letters map the same shifted or not.
   function automatic logic [8:0] xlate(input logic [7:0] sc, input logic sh);
      logic [8:0] res;
      res = 9'h000;
      case (sc)
         8'h1C: res = 9'h1C1;  8'h32: res = 9'h1C2;  8'h21: res = 9'h1C3;
         8'h23: res = 9'h1C4;  8'h24: res = 9'h1C5;  8'h2B: res = 9'h1C6;
         8'h34: res = 9'h1C7;  8'h33: res = 9'h1C8;  8'h43: res = 9'h1C9;
         8'h3B: res = 9'h1CA;  8'h42: res = 9'h1CB;  8'h4B: res = 9'h1CC;
         8'h3A: res = 9'h1CD;  8'h31: res = 9'h1CE;  8'h44: res = 9'h1CF;
         8'h4D: res = 9'h1D0;  8'h15: res = 9'h1D1;  8'h2D: res = 9'h1D2;
         8'h1B: res = 9'h1D3;  8'h2C: res = 9'h1D4;  8'h3C: res = 9'h1D5;
         8'h2A: res = 9'h1D6;  8'h1D: res = 9'h1D7;  8'h22: res = 9'h1D8;
         8'h35: res = 9'h1D9;  8'h1A: res = 9'h1DA;
         default: res = 9'h000;
      endcase
      if (!res[8]) begin
         if (sh) begin
            case (sc)
               8'h52: res = 9'h1A2;  8'h16: res = 9'h1A1;  8'h1E: res = 9'h1C0;
               8'h26: res = 9'h1A3;  8'h25: res = 9'h1A4;  8'h2E: res = 9'h1A5;
               8'h36: res = 9'h1DE;  8'h3D: res = 9'h1A6;  8'h46: res = 9'h1A8;
               8'h45: res = 9'h1A9;  8'h3E: res = 9'h1AA;  8'h55: res = 9'h1AB;
               8'h41: res = 9'h1BC;  8'h49: res = 9'h1BE;  8'h4A: res = 9'h1BF;
               8'h4C: res = 9'h1BA;
               default: res = 9'h000;
            endcase
         end else begin
            case (sc)
               8'h45: res = 9'h1B0;  8'h16: res = 9'h1B1;  8'h1E: res = 9'h1B2;
               8'h26: res = 9'h1B3;  8'h25: res = 9'h1B4;  8'h2E: res = 9'h1B5;
               8'h36: res = 9'h1B6;  8'h3D: res = 9'h1B7;  8'h3E: res = 9'h1B8;
               8'h46: res = 9'h1B9;  8'h29: res = 9'h1A0;  8'h5A: res = 9'h18D;
               8'h76: res = 9'h19B;  8'h52: res = 9'h1A7;  8'h55: res = 9'h1BD;
               8'h4C: res = 9'h1BB;  8'h41: res = 9'h1AC;  8'h4E: res = 9'h1AD;
               8'h49: res = 9'h1AE;  8'h4A: res = 9'h1AF;
               default: res = 9'h000;
            endcase
         end
      end
      return res;
   endfunction

   assign w_xl = xlate(r_byte, r_lshift | r_rshift);

   always_comb begin
      w_break_next  = r_break;
      w_ext_next    = r_ext;
      w_lshift_next = r_lshift;
      w_rshift_next = r_rshift;
      w_push        = 1'b0;
      w_push_data   = r_byte;

      if (r_emit) begin
         if (bus.raw_mode)
            w_push = 1'b1;
         if (r_byte == 8'hF0) begin
            w_break_next = 1'b1;
         end else if (r_byte == 8'hE0) begin
            w_ext_next = 1'b1;
         end else if (r_break) begin
            w_break_next = 1'b0;
            w_ext_next   = 1'b0;
            if (r_byte == 8'h12) w_lshift_next = 1'b0;
            if (r_byte == 8'h59) w_rshift_next = 1'b0;
         end else if (r_byte == 8'h12 || r_byte == 8'h59) begin
            // E0 12 is a fake shift sent around some extended keys.
            if (!r_ext) begin
               if (r_byte == 8'h12) w_lshift_next = 1'b1;
               else                 w_rshift_next = 1'b1;
            end
            w_ext_next = 1'b0;
         end else if (r_ext) begin
            w_ext_next = 1'b0;
            if (!bus.raw_mode) begin
               case (r_byte)
                  8'h6B: begin w_push = 1'b1; w_push_data = 8'h88; end
                  8'h74: begin w_push = 1'b1; w_push_data = 8'h95; end
                  8'h5A: begin w_push = 1'b1; w_push_data = 8'h8D; end
                  default: w_push = 1'b0;
               endcase
            end
         end else if (!bus.raw_mode && w_xl[8]) begin
            w_push      = 1'b1;
            w_push_data = w_xl[7:0];
         end
      end
   end

   always_ff @(posedge clock or posedge kbd_clr) begin
      if (kbd_clr) begin
         r_emit   <= 1'b0;
         r_byte   <= '0;
         r_break  <= 1'b0;
         r_ext    <= 1'b0;
         r_lshift <= 1'b0;
         r_rshift <= 1'b0;
      end else begin
         r_emit   <= w_emit;
         if (w_emit)
            r_byte <= r_shift;
         r_break  <= w_break_next;
         r_ext    <= w_ext_next;
         r_lshift <= w_lshift_next;
         r_rshift <= w_rshift_next;
      end
   end

   // ---------------- output FIFO ----------------
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rd_ptr, r_wr_ptr, w_rd_next;
   logic [CW-1:0] r_count, w_count_next, w_after_pop;
   logic [7:0]    r_kbd;
   logic          r_frame_err, r_overflow;
   logic          w_pop, w_full, w_push_ok, w_ovf_set;

   assign w_pop        = bus.kbd_rd && (r_count != '0);
   assign w_full       = (r_count == CW'(FIFO_DEPTH));
   assign w_push_ok    = w_push && (!w_full || w_pop);
   assign w_ovf_set    = w_push && w_full && !w_pop;
   assign w_rd_next    = r_rd_ptr + AW'(w_pop);
   assign w_after_pop  = r_count - CW'(w_pop);
   assign w_count_next = w_after_pop + CW'(w_push_ok);

   always_ff @(posedge clock) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= w_push_data;
   end

   always_ff @(posedge clock or posedge kbd_clr) begin
      if (kbd_clr) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_kbd       <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_next;
         r_wr_ptr <= r_wr_ptr + AW'(w_push_ok);
         r_count  <= w_count_next;
         // Registered head; bypass the incoming byte when it becomes head.
         if (w_count_next == '0)
            r_kbd <= 8'h00;
         else if (w_after_pop == '0)
            r_kbd <= w_push_data;
         else
            r_kbd <= r_mem[w_rd_next];
         // A new error in the clearing cycle keeps the flag set.
         r_frame_err <= w_frame_bad | (r_frame_err & ~bus.err_clr);
         r_overflow  <= w_ovf_set   | (r_overflow  & ~bus.err_clr);
      end
   end

   assign bus.kbd       = r_kbd;
   assign bus.kbd_strb  = (r_count != '0);
   assign bus.kbd_count = r_count;
   assign bus.frame_err = r_frame_err;
   assign bus.overflow  = r_overflow;
endmodule
